// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit combinational full subtractor: d = a - b - b_in, with borrow out.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    assign d     = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~a & b_in) | (b & b_in);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b LSB first, one bit per clock, with
// registered result flags that hold until the next completed operation.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned     CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             bin;
    logic             a_msb;
    logic             b_msb;
    logic             d_bit;
    logic             bout_bit;
    logic [WIDTH-1:0] res_next;

    full_sub u_full_sub (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .b_in  (bin),
        .d     (d_bit),
        .b_out (bout_bit)
    );

    // The last RUN edge shifts in the final bit and publishes the result in
    // the same cycle, so the flags are derived from the post-shift value.
    assign res_next = {d_bit, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            bin    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        res_sr <= '0;
                        bin    <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    bin    <= bout_bit;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state  <= ST_DONE;
                        done   <= 1'b1;
                        diff   <= res_next;
                        borrow <= bout_bit;
                        ovf    <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
                        zero   <= (res_next == '0);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub at WIDTH=8.
module tb_serial_sub;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
    logic       zero;

    int tests;
    int fails;

    serial_sub #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a_in),
        .b      (b_in),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .ovf    (ovf),
        .zero   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation and waits (bounded) for done; returns latency in edges.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, output int lat,
                         output logic [7:0] d, output logic br, output logic ov, output logic z);
        a_in  = av;
        b_in  = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
        d  = diff;
        br = borrow;
        ov = ovf;
        z  = zero;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_in = 8'h00; b_in = 8'h00;
        tick(); tick();
        tests++; if (busy   !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done   !== 1'b0)  begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (diff   !== 8'h00) begin fails++; $display("FAIL reset_diff: got %h want 00", diff); end
        tests++; if (borrow !== 1'b0)  begin fails++; $display("FAIL reset_borrow: got %b want 0", borrow); end
        tests++; if (ovf    !== 1'b0)  begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        tests++; if (zero   !== 1'b0)  begin fails++; $display("FAIL reset_zero: got %b want 0", zero); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat; logic [7:0] d; logic br, ov, z;
        a_in = 8'h05; b_in = 8'h03; start = 1'b1;
        tick();
        start = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_run: got %b want 1", busy); end
        lat = 1;
        tick();
        while (!done && lat < 30) begin tick(); lat++; end
        d = diff; br = borrow; ov = ovf; z = zero;
        tests++; if (lat !== 8)     begin fails++; $display("FAIL basic_latency: got %0d want 8", lat); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy_done: got %b want 1", busy); end
        tests++; if (d  !== 8'h02)  begin fails++; $display("FAIL basic_diff: got %h want 02", d); end
        tests++; if (br !== 1'b0)   begin fails++; $display("FAIL basic_borrow: got %b want 0", br); end
        tests++; if (ov !== 1'b0)   begin fails++; $display("FAIL basic_ovf: got %b want 0", ov); end
        tests++; if (z  !== 1'b0)   begin fails++; $display("FAIL basic_zero: got %b want 0", z); end
        a_in = 8'hAA; b_in = 8'h55;
        tick();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy_idle: got %b want 0", busy); end
        tick(); tick();
        tests++; if (diff !== 8'h02) begin fails++; $display("FAIL basic_diff_hold: got %h want 02", diff); end
    endtask

    task automatic test_underflow();
        int lat; logic [7:0] d; logic br, ov, z;
        do_op(8'h03, 8'h05, lat, d, br, ov, z);
        tests++; if (lat !== 8)    begin fails++; $display("FAIL under_latency: got %0d want 8", lat); end
        tests++; if (d  !== 8'hFE) begin fails++; $display("FAIL under_diff: got %h want fe", d); end
        tests++; if (br !== 1'b1)  begin fails++; $display("FAIL under_borrow: got %b want 1", br); end
        tests++; if (ov !== 1'b0)  begin fails++; $display("FAIL under_ovf: got %b want 0", ov); end
        tests++; if (z  !== 1'b0)  begin fails++; $display("FAIL under_zero: got %b want 0", z); end
        tick();
    endtask

    task automatic test_overflow();
        int lat; logic [7:0] d; logic br, ov, z;
        do_op(8'h80, 8'h01, lat, d, br, ov, z);
        tests++; if (d  !== 8'h7F) begin fails++; $display("FAIL ovf_diff: got %h want 7f", d); end
        tests++; if (br !== 1'b0)  begin fails++; $display("FAIL ovf_borrow: got %b want 0", br); end
        tests++; if (ov !== 1'b1)  begin fails++; $display("FAIL ovf_flag: got %b want 1", ov); end
        tests++; if (z  !== 1'b0)  begin fails++; $display("FAIL ovf_zero: got %b want 0", z); end
        tick();
        do_op(8'h37, 8'h37, lat, d, br, ov, z);
        tests++; if (d  !== 8'h00) begin fails++; $display("FAIL zero_diff: got %h want 00", d); end
        tests++; if (z  !== 1'b1)  begin fails++; $display("FAIL zero_flag: got %b want 1", z); end
        tests++; if (br !== 1'b0)  begin fails++; $display("FAIL zero_borrow: got %b want 0", br); end
        tests++; if (ov !== 1'b0)  begin fails++; $display("FAIL zero_ovf: got %b want 0", ov); end
        tick();
    endtask

    // A start pulse with new operands during RUN must be ignored entirely.
    task automatic test_start_busy();
        int n_done; int first_k; logic [7:0] first_d;
        n_done = 0; first_k = -1; first_d = 8'hXX;
        a_in = 8'h10; b_in = 8'h01; start = 1'b1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin start = 1'b1; a_in = 8'hFF; b_in = 8'h00; end
            else start = 1'b0;
            tick();
            if (done) begin
                n_done++;
                if (first_k < 0) begin first_k = k; first_d = diff; end
            end
        end
        tests++; if (n_done !== 1)    begin fails++; $display("FAIL busy_done_count: got %0d want 1", n_done); end
        tests++; if (first_k !== 8)   begin fails++; $display("FAIL busy_latency: got %0d want 8", first_k); end
        tests++; if (first_d !== 8'h0F) begin fails++; $display("FAIL busy_diff: got %h want 0f", first_d); end
    endtask

    task automatic test_reset_mid();
        int lat; int n_done; logic [7:0] d; logic br, ov, z;
        a_in = 8'hF0; b_in = 8'h0F; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        #1;
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0)  begin fails++; $display("FAIL rstmid_done: got %b want 0", done); end
        tests++; if (diff !== 8'h00) begin fails++; $display("FAIL rstmid_diff: got %h want 00", diff); end
        tick();
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done || busy) n_done++;
        end
        tests++; if (n_done !== 0) begin fails++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", n_done); end
        do_op(8'h09, 8'h04, lat, d, br, ov, z);
        tests++; if (lat !== 8)    begin fails++; $display("FAIL rstmid_new_latency: got %0d want 8", lat); end
        tests++; if (d  !== 8'h05) begin fails++; $display("FAIL rstmid_new_diff: got %h want 05", d); end
        tests++; if (br !== 1'b0)  begin fails++; $display("FAIL rstmid_new_borrow: got %b want 0", br); end
        tick();
    endtask

    // Start held high: second op is accepted on the IDLE edge after DONE,
    // so the pulses are 10 edges apart (9 cycles between them).
    task automatic test_back_to_back();
        int n_done; int k1; int k2; logic [7:0] d1, d2; logic br1, br2;
        n_done = 0; k1 = -1; k2 = -1; d1 = 8'hXX; d2 = 8'hXX; br1 = 1'bx; br2 = 1'bx;
        a_in = 8'h20; b_in = 8'h10; start = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            tick();
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    k1 = k; d1 = diff; br1 = borrow;
                    a_in = 8'h01; b_in = 8'h02;
                end else if (n_done == 2) begin
                    k2 = k; d2 = diff; br2 = borrow;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        tests++; if (n_done !== 2)     begin fails++; $display("FAIL b2b_count: got %0d want 2", n_done); end
        tests++; if (k2 - k1 !== 10)   begin fails++; $display("FAIL b2b_spacing: got %0d edges want 10", k2 - k1); end
        tests++; if (d1 !== 8'h10)     begin fails++; $display("FAIL b2b_diff1: got %h want 10", d1); end
        tests++; if (br1 !== 1'b0)     begin fails++; $display("FAIL b2b_borrow1: got %b want 0", br1); end
        tests++; if (d2 !== 8'hFF)     begin fails++; $display("FAIL b2b_diff2: got %h want ff", d2); end
        tests++; if (br2 !== 1'b1)     begin fails++; $display("FAIL b2b_borrow2: got %b want 1", br2); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_underflow();
        test_overflow();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
